// File: rtl/ofdm_dac_if.sv
// ofdm_dac_if: strobe-synchronised, bias-added, saturating DAC output with underrun recovery
// Define DAC_CLIP_EN to clamp samples to +/-CLIP_LEVEL before the bias is added.
module ofdm_dac_if #(
  parameter int WIDTH      = 10,
  parameter int CLIP_LEVEL = 384,
  parameter int TIMEOUT    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_strobe,
  input  logic [WIDTH-1:0] i_bias,
  input  logic             i_clear_err,
  output logic [WIDTH-1:0] o_dac_data,
  output logic             o_dac_clk,
  output logic             o_underrun,
  output logic [15:0]      o_sample_cnt,
  output logic [1:0]       o_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, UNDERRUN = 2'd2} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [WIDTH+1:0] CLIP_P = (WIDTH+2)'(CLIP_LEVEL);
`ifdef DAC_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif
  state_t                   state;
  logic                     strobe_d, pend, edge_det, accept, timeout;
  logic [CW-1:0]            idle_cnt;
  logic signed [WIDTH+1:0]  ext, smp, sum;
  logic [WIDTH-1:0]         sat;
  assign o_state = state;
  always_comb begin
    edge_det = i_strobe & ~strobe_d;
    accept   = edge_det & i_enable;
    timeout  = i_enable && state == RUN && !edge_det && idle_cnt + CW'(1) == CW'(TIMEOUT);
    ext      = {{2{i_sample[WIDTH-1]}}, i_sample};
    smp      = (CLIP_ON && ext > CLIP_P) ? CLIP_P : (CLIP_ON && ext < -CLIP_P) ? -CLIP_P : ext;
    sum      = smp + $signed({2'b00, i_bias});
    sat      = sum[WIDTH+1] ? '0 : sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      strobe_d     <= 1'b0;
      pend         <= 1'b0;
      idle_cnt     <= '0;
      o_dac_data   <= '0;
      o_dac_clk    <= 1'b0;
      o_underrun   <= 1'b0;
      o_sample_cnt <= '0;
    end else begin
      strobe_d <= i_strobe;
      if (!i_enable) begin
        state      <= IDLE;
        pend       <= 1'b0;
        o_dac_clk  <= 1'b0;
        o_dac_data <= i_bias;
        idle_cnt   <= '0;
      end else if (accept) begin
        state        <= RUN;
        pend         <= 1'b1;
        o_dac_clk    <= pend;
        o_dac_data   <= sat;
        idle_cnt     <= '0;
        o_sample_cnt <= o_sample_cnt + 16'd1;
      end else if (state == RUN) begin
        pend      <= 1'b0;
        o_dac_clk <= pend;
        idle_cnt  <= idle_cnt + CW'(1);
        if (timeout) state <= UNDERRUN;
      end else begin
        pend       <= 1'b0;
        idle_cnt   <= '0;
        o_dac_data <= i_bias;
        o_dac_clk  <= state == UNDERRUN ? ~o_dac_clk : 1'b0;
      end
      o_underrun <= timeout ? 1'b1 : i_clear_err ? 1'b0 : o_underrun;
    end
  end
endmodule
